// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic                   wr;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready request channel plus the shared read response.
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Combinational one-hot pick: first set request bit at or after the start pointer, wrapping around.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] req_rot2;
  logic [2*NREQ-1:0] grant_rot2;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   rot_grant;

  // Rotate so the pointer lands on bit 0, isolate the lowest set bit, then rotate back.
  always_comb begin
    req_rot2   = {req, req} >> ptr;
    rot_req    = req_rot2[NREQ-1:0];
    rot_grant  = rot_req & (-rot_req);
    grant_rot2 = {rot_grant, rot_grant} << ptr;
    grant      = grant_rot2[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between NREQ requesters (core load/store and program loader).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  req_bus,
  output logic                wr,
  output logic                rd,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   rd_data
);

  localparam int        PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int        CW   = $clog2(MAX_WAIT + 1);
  localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   pick_ptr;
  logic [CW-1:0]   wait_cnt [NREQ];
  logic [NREQ-1:0] aged;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_grant;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rsp_owner;
  logic            rsp_flag;

  // Fixed mode narrows the candidates to starved requesters whenever any has aged out.
  always_comb begin
    aged = '0;
    for (int i = 0; i < NREQ; i++) begin
      aged[i] = req_bus.req_valid[i] && (wait_cnt[i] == CW'(MAX_WAIT));
    end
    if (MODE == ARB_RR) begin
      pick_req = req_bus.req_valid;
      pick_ptr = rr_ptr;
    end else begin
      pick_req = (|aged) ? aged : req_bus.req_valid;
      pick_ptr = '0;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_grant)
  );

  assign grant = reset ? '0 : pick_grant;

  always_comb begin
    next_ptr = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_comb begin
    wr      = 1'b0;
    rd      = 1'b0;
    addr    = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wr      = req_bus.req_wr[i];
        rd      = ~req_bus.req_wr[i];
        addr    = req_bus.req_addr[i*ADDR_W +: ADDR_W];
        wr_data = req_bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Masking with reset drops a response whose read was accepted just before reset arrived.
  assign req_bus.req_ready = grant;
  assign req_bus.rsp_valid = (rsp_flag && !reset) ? rsp_owner : '0;
  assign req_bus.rsp_rdata = (rsp_flag && !reset) ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rsp_flag  <= 1'b0;
      rsp_owner <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      rsp_flag  <= rd;
      rsp_owner <= rd ? grant : '0;
      if (|grant) rr_ptr <= next_ptr;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_bus.req_valid[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CW'(MAX_WAIT)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench: one round-robin and one fixed-priority arbiter, each with its own RAM, checked against a transaction-level model.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int NREQ     = 2;
  localparam int AW       = DMEM_ADDR_W;
  localparam int DW       = DMEM_DATA_W;
  localparam int MAX_WAIT = 8;
  localparam int NINST    = 2;
  localparam int DEPTH    = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
  dmem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus_fx ();

  logic          mem_wr    [NINST];
  logic          mem_rd    [NINST];
  logic [AW-1:0] mem_addr  [NINST];
  logic [DW-1:0] mem_wdata [NINST];
  logic [DW-1:0] mem_rdata [NINST];

  dmem_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_WAIT(MAX_WAIT)
  ) dut_rr (
    .clk(clk), .reset(reset), .req_bus(bus_rr),
    .wr(mem_wr[0]), .rd(mem_rd[0]), .addr(mem_addr[0]),
    .wr_data(mem_wdata[0]), .rd_data(mem_rdata[0])
  );

  dmem_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_WAIT(MAX_WAIT)
  ) dut_fx (
    .clk(clk), .reset(reset), .req_bus(bus_fx),
    .wr(mem_wr[1]), .rd(mem_rd[1]), .addr(mem_addr[1]),
    .wr_data(mem_wdata[1]), .rd_data(mem_rdata[1])
  );

  logic [DW-1:0] ram [NINST][DEPTH];

  // Synchronous single-port RAM per arbiter: write at the edge, read data one cycle after rd.
  always @(posedge clk) begin
    for (int n = 0; n < NINST; n++) begin
      if (mem_wr[n]) ram[n][mem_addr[n]] = mem_wdata[n];
      if (mem_rd[n]) mem_rdata[n] <= ram[n][mem_addr[n]];
    end
  end

  int compared   = 0;
  int mismatched = 0;

  logic          rst_drive;
  bit            hold    [NINST][NREQ];
  dmem_req_t     cur     [NINST][NREQ];
  int            m_ptr   [NINST];
  int            m_wait  [NINST][NREQ];
  bit            m_pend  [NINST];
  int            m_owner [NINST];
  logic [DW-1:0] m_data  [NINST];
  logic [DW-1:0] shadow  [NINST][DEPTH];

  logic [NREQ-1:0] obs_ready [NINST];
  logic [NREQ-1:0] obs_rsp   [NINST];
  logic [DW-1:0]   obs_rdata [NINST];
  logic            obs_wr    [NINST];
  logic            obs_rd    [NINST];
  logic [AW-1:0]   obs_addr  [NINST];
  logic [DW-1:0]   obs_wdata [NINST];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic arm(input int n, input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    hold[n][i]      = 1'b1;
    cur[n][i].wr    = w;
    cur[n][i].addr  = a;
    cur[n][i].wdata = d;
  endtask

  task automatic apply_stimulus();
    reset = rst_drive;
    for (int i = 0; i < NREQ; i++) begin
      bus_rr.req_valid[i]            = hold[0][i];
      bus_rr.req_wr[i]               = cur[0][i].wr;
      bus_rr.req_addr[i*AW +: AW]    = cur[0][i].addr;
      bus_rr.req_wdata[i*DW +: DW]   = cur[0][i].wdata;
      bus_fx.req_valid[i]            = hold[1][i];
      bus_fx.req_wr[i]               = cur[1][i].wr;
      bus_fx.req_addr[i*AW +: AW]    = cur[1][i].addr;
      bus_fx.req_wdata[i*DW +: DW]   = cur[1][i].wdata;
    end
  endtask

  task automatic sample();
    obs_ready[0] = bus_rr.req_ready;
    obs_rsp[0]   = bus_rr.rsp_valid;
    obs_rdata[0] = bus_rr.rsp_rdata;
    obs_ready[1] = bus_fx.req_ready;
    obs_rsp[1]   = bus_fx.rsp_valid;
    obs_rdata[1] = bus_fx.rsp_rdata;
    for (int n = 0; n < NINST; n++) begin
      obs_wr[n]    = mem_wr[n];
      obs_rd[n]    = mem_rd[n];
      obs_addr[n]  = mem_addr[n];
      obs_wdata[n] = mem_wdata[n];
    end
  endtask

  // Instance 0 rotates fairly from the last winner; instance 1 favours index 0 unless someone has starved.
  function automatic int model_pick(input int n);
    if (reset) return -1;
    if (n == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_ptr[n] + k) % NREQ;
        if (hold[n][i]) return i;
      end
      return -1;
    end
    for (int i = 0; i < NREQ; i++) if (hold[n][i] && m_wait[n][i] >= MAX_WAIT) return i;
    for (int i = 0; i < NREQ; i++) if (hold[n][i]) return i;
    return -1;
  endfunction

  task automatic run_cycle();
    int g;
    @(negedge clk);
    apply_stimulus();
    #1;
    sample();
    for (int n = 0; n < NINST; n++) begin
      logic [NREQ-1:0] exp_ready;
      logic [NREQ-1:0] exp_rsp;
      logic            exp_wr;
      logic            exp_rd;
      logic [AW-1:0]   exp_addr;
      logic [DW-1:0]   exp_wdata;
      g         = model_pick(n);
      exp_ready = '0;
      exp_rsp   = '0;
      exp_wr    = 1'b0;
      exp_rd    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        exp_wr       = cur[n][g].wr;
        exp_rd       = !cur[n][g].wr;
        exp_addr     = cur[n][g].addr;
        exp_wdata    = cur[n][g].wdata;
      end
      if (m_pend[n] && !reset) exp_rsp[m_owner[n]] = 1'b1;
      check_output($sformatf("i%0d_ready", n), obs_ready[n], exp_ready);
      check_output($sformatf("i%0d_wr", n), obs_wr[n], exp_wr);
      check_output($sformatf("i%0d_rd", n), obs_rd[n], exp_rd);
      check_output($sformatf("i%0d_addr", n), obs_addr[n], exp_addr);
      check_output($sformatf("i%0d_wdata", n), obs_wdata[n], exp_wdata);
      check_output($sformatf("i%0d_rsp_valid", n), obs_rsp[n], exp_rsp);
      if (reset) check_output($sformatf("i%0d_rdata_rst", n), obs_rdata[n], '0);
      else if (exp_rsp != '0) check_output($sformatf("i%0d_rdata", n), obs_rdata[n], m_data[n]);

      if (reset) begin
        m_ptr[n]  = 0;
        m_pend[n] = 1'b0;
        for (int i = 0; i < NREQ; i++) m_wait[n][i] = 0;
      end else begin
        m_pend[n] = (g >= 0) && !cur[n][g].wr;
        if (g >= 0) begin
          m_owner[n] = g;
          if (cur[n][g].wr) shadow[n][cur[n][g].addr] = cur[n][g].wdata;
          else              m_data[n] = shadow[n][cur[n][g].addr];
          m_ptr[n] = (g + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!hold[n][i] || i == g) m_wait[n][i] = 0;
          else if (m_wait[n][i] < MAX_WAIT) m_wait[n][i]++;
        end
        if (g >= 0) hold[n][g] = 1'b0;
      end
    end
  endtask

  task automatic clear_holds();
    for (int n = 0; n < NINST; n++) for (int i = 0; i < NREQ; i++) hold[n][i] = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rst_drive = 1'b1;
    for (int n = 0; n < NINST; n++) begin
      m_ptr[n]   = 0;
      m_pend[n]  = 1'b0;
      m_owner[n] = 0;
      m_data[n]  = '0;
      for (int i = 0; i < NREQ; i++) begin
        hold[n][i]   = 1'b0;
        cur[n][i]    = '0;
        m_wait[n][i] = 0;
      end
      for (int a = 0; a < DEPTH; a++) begin
        ram[n][a]    = $urandom;
        shadow[n][a] = ram[n][a];
      end
    end
    ram[0][5]    = 32'hDEAD_BEEF;
    shadow[0][5] = 32'hDEAD_BEEF;
    apply_stimulus();

    $display("[TB] reset held with every requester valid");
    for (int n = 0; n < NINST; n++) for (int i = 0; i < NREQ; i++) arm(n, i, 1'b0, AW'(i), '0);
    repeat (3) begin
      run_cycle();
      check_output("t1_ready", obs_ready[0], 2'b00);
      check_output("t1_rd", obs_rd[0], 1'b0);
      check_output("t1_rsp", obs_rsp[1], 2'b00);
    end
    clear_holds();
    run_cycle();
    rst_drive = 1'b0;
    run_cycle();

    $display("[TB] single read from requester 0");
    arm(0, 0, 1'b0, 9'h005, '0);
    run_cycle();
    check_output("t2_ready", obs_ready[0], 2'b01);
    check_output("t2_rd", obs_rd[0], 1'b1);
    check_output("t2_addr", obs_addr[0], 9'h005);
    run_cycle();
    check_output("t2_rsp", obs_rsp[0], 2'b01);
    check_output("t2_rdata", obs_rdata[0], 32'hDEAD_BEEF);

    $display("[TB] round-robin contention");
    rst_drive = 1'b1;
    run_cycle();
    rst_drive = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NREQ; i++) if (!hold[0][i]) arm(0, i, 1'b0, AW'(k + 16), '0);
      run_cycle();
      check_output($sformatf("t3_grant%0d", k), obs_ready[0], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check_output($sformatf("t3_rsp%0d", k), obs_rsp[0], (k % 2 == 1) ? 2'b01 : 2'b10);
    end
    run_cycle();
    check_output("t3_rsp_last", obs_rsp[0], 2'b10);

    $display("[TB] write then read of the top address");
    arm(0, 1, 1'b1, 9'h1FF, 32'h1234_5678);
    run_cycle();
    check_output("t4_wr_ready", obs_ready[0], 2'b10);
    check_output("t4_wr", obs_wr[0], 1'b1);
    arm(0, 1, 1'b0, 9'h1FF, '0);
    run_cycle();
    check_output("t4_rd_ready", obs_ready[0], 2'b10);
    run_cycle();
    check_output("t4_rsp", obs_rsp[0], 2'b10);
    check_output("t4_rdata", obs_rdata[0], 32'h1234_5678);

    $display("[TB] fixed priority with aging");
    rst_drive = 1'b1;
    run_cycle();
    rst_drive = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < NREQ; i++) if (!hold[1][i]) arm(1, i, 1'b0, AW'(k), '0);
      run_cycle();
      check_output($sformatf("t5_grant%0d", k), obs_ready[1], (k == 9) ? 2'b10 : 2'b01);
    end
    run_cycle();

    $display("[TB] reset during an outstanding read");
    arm(0, 0, 1'b0, 9'h005, '0);
    run_cycle();
    check_output("t6_accept", obs_ready[0], 2'b01);
    rst_drive = 1'b1;
    arm(0, 0, 1'b0, 9'h005, '0);
    arm(0, 1, 1'b0, 9'h006, '0);
    run_cycle();
    check_output("t6_rsp", obs_rsp[0], 2'b00);
    check_output("t6_ready", obs_ready[0], 2'b00);
    rst_drive = 1'b0;
    run_cycle();
    check_output("t6_first", obs_ready[0], 2'b01);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      rst_drive = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < NINST; n++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!hold[n][i] && $urandom_range(0, 99) < 60) begin
            arm(n, i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 9'h1FF : AW'($urandom_range(0, 15)),
                $urandom);
          end
        end
      end
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
